// File: rtl/mul_arbiter_pkg.sv
// Shared definitions for the two-requester multiplier arbiter.
//   W_DEFAULT       : default operand width (result is 2*W)
//   MUL_LAT_DEFAULT : default latency of the external multiplier, in cycles
//   state_t         : arbiter FSM state encoding
package mul_arbiter_pkg;

  localparam int unsigned W_DEFAULT       = 9;
  localparam int unsigned MUL_LAT_DEFAULT = 10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/mul_arbiter_rr_arb2.sv
// Two-way round-robin grant selection with a registered priority pointer.
//   clk, reset : clock, asynchronous active-high reset
//   req0, req1 : effective requests
//   update     : record a completed service this cycle
//   served     : index of the requester whose transfer just completed
//   any_c      : at least one request present (combinational)
//   winner_c   : index of the selected requester (combinational)
module rr_arb2 (
  input  logic clk,
  input  logic reset,
  input  logic req0,
  input  logic req1,
  input  logic update,
  input  logic served,
  output logic any_c,
  output logic winner_c
);

  // 0: requester 0 wins a tie, 1: requester 1 wins a tie
  logic prio;

  // The requester that was not served last gets the next tie.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prio <= 1'b0;
    end else if (update) begin
      prio <= ~served;
    end
  end

  // A lone requester wins outright; the pointer only breaks ties.
  always_comb begin
    any_c    = req0 | req1;
    winner_c = 1'b0;
    if (req0 && req1) begin
      winner_c = prio;
    end else if (req1) begin
      winner_c = 1'b1;
    end
  end

endmodule

// File: rtl/mul_arbiter.sv
// Arbitrates two requesters onto one external multiplier.
//   clk, reset         : clock, asynchronous active-high reset
//   req0/req1          : requests; a0/b0, a1/b1 their operands
//   gnt0/gnt1          : requester owns the multiplier (START..DONE)
//   done0/done1        : one-cycle pulse, res holds that requester's product
//   res                : last captured product, held until the next capture
//   busy               : FSM is not in IDLE
//   mul_a/mul_b        : operands to the multiplier
//   mul_reset          : one-cycle start strobe to the multiplier
//   mul_res            : product from the multiplier
module mul_arbiter
  import mul_arbiter_pkg::*;
#(
  parameter int unsigned W       = W_DEFAULT,
  parameter int unsigned MUL_LAT = MUL_LAT_DEFAULT
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           req0,
  input  logic           req1,
  input  logic [W-1:0]   a0,
  input  logic [W-1:0]   b0,
  input  logic [W-1:0]   a1,
  input  logic [W-1:0]   b1,
  output logic           gnt0,
  output logic           gnt1,
  output logic           done0,
  output logic           done1,
  output logic [2*W-1:0] res,
  output logic           busy,
  output logic [W-1:0]   mul_a,
  output logic [W-1:0]   mul_b,
  output logic           mul_reset,
  input  logic [2*W-1:0] mul_res
);

  localparam int unsigned CW = (MUL_LAT < 2) ? 1 : $clog2(MUL_LAT + 1);

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            owner_q, owner_d;
  logic            pend0_q, pend0_d;
  logic            pend1_q, pend1_d;

  logic            gnt0_d, gnt1_d, done0_d, done1_d, busy_d, mul_reset_d;
  logic [W-1:0]    mul_a_d, mul_b_d;
  logic [2*W-1:0]  res_d;

  logic            eff_req0_c, eff_req1_c;
  logic            arb_any_c, arb_win_c, arb_update_c;

  // A request seen while busy is remembered so a short pulse is not lost.
  assign eff_req0_c = req0 | pend0_q;
  assign eff_req1_c = req1 | pend1_q;

  rr_arb2 u_arb (
    .clk      (clk),
    .reset    (reset),
    .req0     (eff_req0_c),
    .req1     (eff_req1_c),
    .update   (arb_update_c),
    .served   (owner_q),
    .any_c    (arb_any_c),
    .winner_c (arb_win_c)
  );

  // Next state and next registered outputs.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    owner_d      = owner_q;
    pend0_d      = pend0_q;
    pend1_d      = pend1_q;
    gnt0_d       = gnt0;
    gnt1_d       = gnt1;
    done0_d      = 1'b0;
    done1_d      = 1'b0;
    mul_reset_d  = 1'b0;
    mul_a_d      = mul_a;
    mul_b_d      = mul_b;
    res_d        = res;
    arb_update_c = 1'b0;

    if (state_q != IDLE) begin
      if (req0 && owner_q)  pend0_d = 1'b1;
      if (req1 && !owner_q) pend1_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (arb_any_c) begin
          state_d     = START;
          owner_d     = arb_win_c;
          gnt0_d      = ~arb_win_c;
          gnt1_d      = arb_win_c;
          mul_reset_d = 1'b1;
          mul_a_d     = arb_win_c ? a1 : a0;
          mul_b_d     = arb_win_c ? b1 : b0;
          if (arb_win_c) pend1_d = 1'b0;
          else           pend0_d = 1'b0;
        end
      end
      START: begin
        // mul_res settles MUL_LAT cycles after the strobe falls; counting
        // down from MUL_LAT samples it on the edge after it is stable.
        state_d = WAIT;
        cnt_d   = CW'(MUL_LAT);
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d      = DONE;
          res_d        = mul_res;
          done0_d      = ~owner_q;
          done1_d      = owner_q;
          arb_update_c = 1'b1;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
        gnt0_d  = 1'b0;
        gnt1_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        gnt0_d  = 1'b0;
        gnt1_d  = 1'b0;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      owner_q   <= 1'b0;
      pend0_q   <= 1'b0;
      pend1_q   <= 1'b0;
      gnt0      <= 1'b0;
      gnt1      <= 1'b0;
      done0     <= 1'b0;
      done1     <= 1'b0;
      busy      <= 1'b0;
      mul_reset <= 1'b0;
      mul_a     <= '0;
      mul_b     <= '0;
      res       <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      owner_q   <= owner_d;
      pend0_q   <= pend0_d;
      pend1_q   <= pend1_d;
      gnt0      <= gnt0_d;
      gnt1      <= gnt1_d;
      done0     <= done0_d;
      done1     <= done1_d;
      busy      <= busy_d;
      mul_reset <= mul_reset_d;
      mul_a     <= mul_a_d;
      mul_b     <= mul_b_d;
      res       <= res_d;
    end
  end

endmodule

// File: tb/tb_mul_arbiter.sv
// Self-checking bench for mul_arbiter with a behavioural multiplier model.
module tb_mul_arbiter;

  localparam int unsigned W       = 9;
  localparam int unsigned RW      = 2 * W;
  localparam int unsigned MUL_LAT = 10;
  localparam int          LAT_EXP = MUL_LAT + 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          req0 = 1'b0, req1 = 1'b0;
  logic [W-1:0]  a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic          gnt0, gnt1, done0, done1, busy, mul_reset;
  logic [RW-1:0] res;
  logic [W-1:0]  mul_a, mul_b;
  logic [RW-1:0] mul_res = '0;

  int checks = 0;
  int errors = 0;

  // Reference model state: index of the requester served last.
  int last_served = 1;

  // Protocol monitor tallies, compared inside the tests.
  int excl_viol = 0;
  int mr_viol   = 0;
  logic mr_prev = 1'b0;

  mul_arbiter #(.W(W), .MUL_LAT(MUL_LAT)) dut (
    .clk       (clk),
    .reset     (reset),
    .req0      (req0),
    .req1      (req1),
    .a0        (a0),
    .b0        (b0),
    .a1        (a1),
    .b1        (b1),
    .gnt0      (gnt0),
    .gnt1      (gnt1),
    .done0     (done0),
    .done1     (done1),
    .res       (res),
    .busy      (busy),
    .mul_a     (mul_a),
    .mul_b     (mul_b),
    .mul_reset (mul_reset),
    .mul_res   (mul_res)
  );

  always #5 clk = ~clk;

  // Multiplier model: product appears MUL_LAT cycles after the strobe falls,
  // garbage before that.
  logic [W-1:0] m_a = '0, m_b = '0;
  int           m_cnt = 0;
  always @(posedge clk) begin
    if (mul_reset) begin
      m_a     <= mul_a;
      m_b     <= mul_b;
      m_cnt   <= MUL_LAT;
      mul_res <= '1;
    end else if (m_cnt > 0) begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 1) mul_res <= RW'(m_a) * RW'(m_b);
    end
  end

  // Exclusivity, grant/busy/done consistency and strobe width.
  always @(negedge clk) begin
    if (!reset) begin
      if ((gnt0 && gnt1) || (done0 && done1) || (busy !== (gnt0 | gnt1)) ||
          (done0 && !gnt0) || (done1 && !gnt1))
        excl_viol <= excl_viol + 1;
      if (mul_reset && mr_prev) mr_viol <= mr_viol + 1;
      mr_prev <= mul_reset;
    end else begin
      mr_prev <= 1'b0;
    end
  end

  function automatic int model_pick(bit r0, bit r1);
    if (r0 && r1) return 1 - last_served;
    return r1 ? 1 : 0;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    req0 = 1'b0; req1 = 1'b0; reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    last_served = 1;
  endtask

  // Waits for the next done pulse; latency is measured from the grant rise.
  task automatic wait_xfer(output int lat, output logic [1:0] dn,
                           output logic [RW-1:0] r, output bit to);
    int g;
    g = -1; lat = -1; dn = '0; r = '0; to = 1'b1;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk); #1;
      if (g < 0 && (gnt0 || gnt1)) g = k;
      if (done0 || done1) begin
        dn = {done1, done0}; r = res; lat = k - g; to = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({gnt0, gnt1, done0, done1, busy, mul_reset} !== 6'b0) begin
      errors++; $display("FAIL reset_ctrl: got %b expected 000000",
                         {gnt0, gnt1, done0, done1, busy, mul_reset});
    end
    checks++;
    if ({mul_a, mul_b, res} !== '0) begin
      errors++; $display("FAIL reset_data: got %0h expected 0", {mul_a, mul_b, res});
    end
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || gnt0 !== 1'b0) begin
      errors++; $display("FAIL idle_no_req: busy %b gnt0 %b expected 0 0", busy, gnt0);
    end
  endtask

  task automatic test_single();
    int k;
    @(negedge clk);
    a0 = 9'd25; b0 = 9'd20; req0 = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({gnt0, gnt1, mul_reset, mul_a, mul_b} !== {3'b101, 9'd25, 9'd20}) begin
      errors++; $display("FAIL grant_edge: gnt0 %b gnt1 %b mul_reset %b a %0d b %0d expected 1 0 1 25 20",
                         gnt0, gnt1, mul_reset, mul_a, mul_b);
    end
    a0 = W'($urandom_range(0, 511)); b0 = W'($urandom_range(0, 511));
    @(posedge clk); #1;
    checks++;
    if (mul_reset !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL strobe_width: mul_reset %b busy %b expected 0 1", mul_reset, busy);
    end
    k = 1;
    while (k < 40) begin
      @(posedge clk); #1;
      k++;
      if (done0 || done1) break;
    end
    req0 = 1'b0;
    checks++;
    if (k !== LAT_EXP) begin
      errors++; $display("FAIL single_latency: got %0d expected %0d", k, LAT_EXP);
    end
    checks++;
    if ({done0, done1} !== 2'b10 || res !== RW'(500)) begin
      errors++; $display("FAIL single_result: done %b res %0d expected 10 500", {done0, done1}, res);
    end
    last_served = 0;
    @(posedge clk); #1;
    checks++;
    if ({done0, gnt0, busy} !== 3'b000) begin
      errors++; $display("FAIL single_release: done0 gnt0 busy %b expected 000", {done0, gnt0, busy});
    end
  endtask

  task automatic test_both_first();
    int lat; logic [1:0] dn; logic [RW-1:0] r; bit to;
    do_reset();
    @(negedge clk);
    a0 = 9'd24; b0 = 9'd26; a1 = 9'd6; b1 = 9'd23;
    req0 = 1'b1; req1 = 1'b1;
    wait_xfer(lat, dn, r, to);
    req0 = 1'b0;
    checks++;
    if (to || dn !== 2'b01 || r !== RW'(624) || lat !== LAT_EXP) begin
      errors++; $display("FAIL both_first0: done %b res %0d lat %0d expected 01 624 %0d", dn, r, lat, LAT_EXP);
    end
    last_served = 0;
    wait_xfer(lat, dn, r, to);
    req1 = 1'b0;
    checks++;
    if (to || dn !== 2'b10 || r !== RW'(138) || lat !== LAT_EXP) begin
      errors++; $display("FAIL both_first1: done %b res %0d lat %0d expected 10 138 %0d", dn, r, lat, LAT_EXP);
    end
    last_served = 1;
    checks++;
    if (excl_viol !== 0) begin
      errors++; $display("FAIL exclusive: got %0d violations expected 0", excl_viol);
    end
  endtask

  task automatic test_back_to_back();
    int lat, w; logic [1:0] dn, exp_dn; logic [RW-1:0] r, exp_r; bit to;
    do_reset();
    @(negedge clk);
    a0 = 9'd43; b0 = 9'd33; a1 = 9'd341; b1 = 9'd345;
    req0 = 1'b1; req1 = 1'b1;
    // Requester 0 is still waiting when both drop, so a fifth transfer follows.
    for (int t = 0; t < 5; t++) begin
      w = (t < 4) ? model_pick(1'b1, 1'b1) : model_pick(1'b1, 1'b0);
      exp_dn = (w == 1) ? 2'b10 : 2'b01;
      exp_r  = (w == 1) ? RW'(a1) * RW'(b1) : RW'(a0) * RW'(b0);
      wait_xfer(lat, dn, r, to);
      if (t == 3) begin req0 = 1'b0; req1 = 1'b0; end
      checks++;
      if (to || dn !== exp_dn || r !== exp_r || lat !== LAT_EXP) begin
        errors++; $display("FAIL b2b_%0d: done %b res %0d lat %0d expected %b %0d %0d",
                           t, dn, r, lat, exp_dn, exp_r, LAT_EXP);
      end
      last_served = w;
    end
    repeat (4) @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL b2b_idle: busy %b expected 0", busy);
    end
  endtask

  task automatic test_max();
    int lat; logic [1:0] dn; logic [RW-1:0] r; bit to;
    @(negedge clk);
    a1 = 9'd511; b1 = 9'd511; req1 = 1'b1;
    wait_xfer(lat, dn, r, to);
    req1 = 1'b0;
    checks++;
    if (to || dn !== 2'b10 || r !== RW'(261121)) begin
      errors++; $display("FAIL max_product: done %b res %0d expected 10 261121", dn, r);
    end
    last_served = 1;
    repeat (6) @(negedge clk);
    checks++;
    if (res !== RW'(261121) || busy !== 1'b0 || done1 !== 1'b0) begin
      errors++; $display("FAIL max_hold: res %0d busy %b done1 %b expected 261121 0 0", res, busy, done1);
    end
  endtask

  task automatic test_pending();
    int lat; logic [1:0] dn; logic [RW-1:0] r, p0, p1; bit to;
    @(negedge clk);
    a0 = W'($urandom_range(0, 511)); b0 = W'($urandom_range(0, 511));
    a1 = W'($urandom_range(0, 511)); b1 = W'($urandom_range(0, 511));
    p0 = RW'(a0) * RW'(b0); p1 = RW'(a1) * RW'(b1);
    req0 = 1'b1;
    @(posedge clk); #1;
    req0 = 1'b0;
    repeat (3) @(negedge clk);
    req1 = 1'b1;
    @(negedge clk);
    req1 = 1'b0;
    wait_xfer(lat, dn, r, to);
    checks++;
    if (to || dn !== 2'b01 || r !== p0) begin
      errors++; $display("FAIL drop_no_abort: done %b res %0d expected 01 %0d", dn, r, p0);
    end
    last_served = 0;
    wait_xfer(lat, dn, r, to);
    checks++;
    if (to || dn !== 2'b10 || r !== p1 || lat !== LAT_EXP) begin
      errors++; $display("FAIL pending_served: done %b res %0d lat %0d expected 10 %0d %0d", dn, r, lat, p1, LAT_EXP);
    end
    last_served = 1;
  endtask

  task automatic test_reset_mid();
    int lat; logic [1:0] dn; logic [RW-1:0] r; bit to, seen;
    @(negedge clk);
    a0 = 9'd25; b0 = 9'd20; req0 = 1'b1;
    repeat (6) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({gnt0, gnt1, done0, done1, busy, mul_reset} !== 6'b0 || {mul_a, mul_b, res} !== '0) begin
      errors++; $display("FAIL async_reset: ctrl %b data %0h expected 0 0",
                         {gnt0, gnt1, done0, done1, busy, mul_reset}, {mul_a, mul_b, res});
    end
    @(negedge clk);
    req0 = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    last_served = 1;
    seen = 1'b0;
    repeat (16) begin
      @(posedge clk); #1;
      if (done0 || done1 || busy) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++; $display("FAIL reset_drops: got activity %b expected 0", seen);
    end
    @(negedge clk);
    req0 = 1'b1;
    wait_xfer(lat, dn, r, to);
    req0 = 1'b0;
    checks++;
    if (to || dn !== 2'b01 || r !== RW'(500) || lat !== LAT_EXP) begin
      errors++; $display("FAIL after_reset: done %b res %0d lat %0d expected 01 500 %0d", dn, r, lat, LAT_EXP);
    end
    last_served = 0;
  endtask

  task automatic test_random();
    int pat, w, lat; bit p0, p1, to; logic [1:0] dn, exp_dn; logic [RW-1:0] r, exp_r;
    for (int it = 0; it < 10; it++) begin
      @(negedge clk);
      pat = int'($urandom_range(1, 3));
      p0 = (pat & 1) != 0; p1 = (pat & 2) != 0;
      a0 = W'($urandom_range(0, 511)); b0 = W'($urandom_range(0, 511));
      a1 = W'($urandom_range(0, 511)); b1 = W'($urandom_range(0, 511));
      req0 = p0; req1 = p1;
      while (p0 || p1) begin
        w = model_pick(p0, p1);
        exp_dn = (w == 1) ? 2'b10 : 2'b01;
        exp_r  = (w == 1) ? RW'(a1) * RW'(b1) : RW'(a0) * RW'(b0);
        wait_xfer(lat, dn, r, to);
        checks++;
        if (to || dn !== exp_dn || r !== exp_r || lat !== LAT_EXP) begin
          errors++; $display("FAIL random_%0d: done %b res %0d lat %0d expected %b %0d %0d",
                             it, dn, r, lat, exp_dn, exp_r, LAT_EXP);
        end
        if (w == 1) begin req1 = 1'b0; p1 = 1'b0; end
        else        begin req0 = 1'b0; p0 = 1'b0; end
        last_served = w;
      end
    end
    repeat (4) @(negedge clk);
    checks++;
    if (excl_viol !== 0 || mr_viol !== 0) begin
      errors++; $display("FAIL protocol: excl %0d strobe %0d expected 0 0", excl_viol, mr_viol);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_both_first();
    test_back_to_back();
    test_max();
    test_pending();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
